// File: rtl/pmbist_scan_loader_if.sv
// Handshake bundle between the scan loader and the BIST memory block:
// instruction word and start strobe out, busy and pass/fail status back.
interface pmbist_scan_loader_if #(
    parameter int SCAN_WIDTH = 24
);
    logic [SCAN_WIDTH-1:0] scan;
    logic                  ts;
    logic                  busy_in;
    logic                  passfail_in;

    modport master (
        output scan,
        output ts,
        input  busy_in,
        input  passfail_in
    );

    modport slave (
        input  scan,
        input  ts,
        output busy_in,
        output passfail_in
    );
endinterface

// File: rtl/pmbist_scan_loader.sv
// Serial instruction loader for the programmable memory BIST: deserialises
// tester words into a command FIFO and sequences them one at a time.
module pmbist_scan_loader #(
    parameter int SCAN_WIDTH    = 24,
    parameter int DEPTH         = 4,
    parameter int TS_CYCLES     = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tdi,
    input  logic                  tshift,
    input  logic                  tupdate,
    pmbist_scan_loader_if.master  bist,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  seq_busy,
    output logic                  fail_flag,
    output logic [7:0]            cmd_count,
    output logic                  load_err,
    output logic                  timeout_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int BW      = $clog2(SCAN_WIDTH + 2);
    localparam int CNT_MAX = (TS_CYCLES > START_TIMEOUT) ? TS_CYCLES : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;

    logic [SCAN_WIDTH-1:0]  sr_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic                   load_err_reg;

    logic [SCAN_WIDTH-1:0]  mem [DEPTH];
    logic [AW:0]            wr_ptr_reg;
    logic [AW:0]            rd_ptr_reg;

    logic [SCAN_WIDTH-1:0]  scan_reg;
    logic                   ts_reg;
    logic                   fail_flag_reg;
    logic                   timeout_err_reg;
    logic [7:0]             cmd_count_reg;

    logic                   push;
    logic                   pop;
    logic                   cmd_done;
    logic                   fail_hit;
    logic                   timeout_hit;

    // ------------------------------------------------------------------
    // Shift path: counter saturates one past full width so an overshift
    // still reads as a bad length at commit time.
    // ------------------------------------------------------------------
    assign push = tupdate && (bit_cnt_reg == BW'(SCAN_WIDTH)) && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg       <= '0;
            bit_cnt_reg  <= '0;
            load_err_reg <= 1'b0;
        end else begin
            if (tupdate) begin
                bit_cnt_reg <= '0;
                if (!push) begin
                    load_err_reg <= 1'b1;
                end
            end else if (tshift) begin
                sr_reg <= {sr_reg[SCAN_WIDTH-2:0], tdi};
                if (bit_cnt_reg != BW'(SCAN_WIDTH + 1)) begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO: storage carries no reset so it maps onto RAM; the
    // extra pointer bit separates full from empty.
    // ------------------------------------------------------------------
    assign pop        = (state_reg == ST_SETUP);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= sr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cmd_done    = 1'b0;
        fail_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
                cnt_next   = '0;
            end
            ST_STROBE: begin
                if (cnt_reg == CW'(TS_CYCLES - 1)) begin
                    state_next = ST_WAIT_START;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (bist.busy_in) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt_reg == CW'(START_TIMEOUT - 1)) begin
                    state_next  = ST_IDLE;
                    timeout_hit = 1'b1;
                    cmd_done    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bist.busy_in) begin
                    state_next = ST_IDLE;
                    cmd_done   = 1'b1;
                    fail_hit   = bist.passfail_in;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ts is registered from the next state so the strobe is glitch-free
    // and lines up exactly with the STROBE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_reg <= '0;
            ts_reg   <= 1'b0;
        end else begin
            ts_reg <= (state_next == ST_STROBE);
            if (pop) begin
                scan_reg <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_flag_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            cmd_count_reg   <= '0;
        end else begin
            if (fail_hit) begin
                fail_flag_reg <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
            if (cmd_done && (cmd_count_reg != 8'hFF)) begin
                cmd_count_reg <= cmd_count_reg + 1'b1;
            end
        end
    end

    assign bist.scan   = scan_reg;
    assign bist.ts     = ts_reg;
    assign seq_busy    = (state_reg != ST_IDLE);
    assign fail_flag   = fail_flag_reg;
    assign cmd_count   = cmd_count_reg;
    assign load_err    = load_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_pmbist_scan_loader.sv
// Scoreboard bench for pmbist_scan_loader: a behavioural BIST responder
// checks every issued command against words the tester model accepted.
module tb_pmbist_scan_loader;

    localparam int SW    = 24;
    localparam int DEPTH = 4;
    localparam int TSC   = 2;
    localparam int STO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tdi = 1'b0;
    logic       tshift = 1'b0;
    logic       tupdate = 1'b0;
    logic       fifo_full, fifo_empty, seq_busy, fail_flag, load_err, timeout_err;
    logic [7:0] cmd_count;

    pmbist_scan_loader_if #(.SCAN_WIDTH(SW)) bist_if ();

    pmbist_scan_loader #(
        .SCAN_WIDTH(SW), .DEPTH(DEPTH), .TS_CYCLES(TSC), .START_TIMEOUT(STO)
    ) dut (
        .clk(clk), .rst(rst), .tdi(tdi), .tshift(tshift), .tupdate(tupdate),
        .bist(bist_if.master),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .seq_busy(seq_busy),
        .fail_flag(fail_flag), .cmd_count(cmd_count), .load_err(load_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference state
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] m_word;
    int            m_cnt, m_occ;
    logic          m_ts_q;
    int            exp_cnt;
    logic          exp_fail, exp_load_err, exp_timeout;

    // responder controls
    int   rsp_delay = 2, rsp_len = 10, rsp_gen = 0;
    logic rsp_pf = 1'b0, rsp_never = 1'b0, rsp_hold = 1'b0, rsp_active = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Tester-side model: last SW bits shifted, bit count saturating one past
    // width, FIFO occupancy reduced each time a command strobe appears.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_cnt = 0; m_occ = 0; m_ts_q = 1'b0; m_word = '0;
                exp_q.delete();
                exp_cnt = 0; exp_fail = 1'b0; exp_load_err = 1'b0; exp_timeout = 1'b0;
            end else begin
                if (bist_if.ts && !m_ts_q) m_occ--;
                m_ts_q = bist_if.ts;
                if (tupdate) begin
                    if (m_cnt == SW && m_occ < DEPTH) begin
                        exp_q.push_back(m_word);
                        m_occ++;
                    end else begin
                        exp_load_err = 1'b1;
                    end
                    m_cnt = 0;
                end else if (tshift) begin
                    m_word = {m_word[SW-2:0], tdi};
                    if (m_cnt < SW + 1) m_cnt++;
                end
            end
        end
    end

    // BIST responder and scoreboard monitor.
    initial begin
        logic [SW-1:0] w, held;
        int n, g;
        bist_if.busy_in = 1'b0;
        bist_if.passfail_in = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bist_if.ts) begin
                rsp_active = 1'b1;
                g = rsp_gen;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("scan_word", bist_if.scan, w);
                end
                held = bist_if.scan;
                n = 0;
                while (bist_if.ts && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("ts_width", n, TSC);
                if (rsp_never) begin
                    n = 0;
                    while (seq_busy && n < 40) begin
                        n++;
                        @(negedge clk);
                    end
                    if (g == rsp_gen) begin
                        check("timeout_cycles", n, STO);
                        exp_timeout = 1'b1;
                        if (exp_cnt < 255) exp_cnt++;
                    end
                end else begin
                    repeat (rsp_delay) @(posedge clk);
                    #1 bist_if.busy_in = 1'b1;
                    n = 0;
                    while ((rsp_hold || n < rsp_len) && g == rsp_gen && n < 5000) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (g == rsp_gen) check("scan_hold", bist_if.scan, held);
                    bist_if.passfail_in = rsp_pf;
                    bist_if.busy_in = 1'b0;
                    if (g == rsp_gen) begin
                        exp_fail = exp_fail | rsp_pf;
                        if (exp_cnt < 255) exp_cnt++;
                    end
                end
                rsp_active = 1'b0;
            end
        end
    end

    task automatic load_word(input logic [SW-1:0] w, input int nbits);
        logic [31:0] ext;
        ext = {8'h00, w};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            tshift = 1'b1;
            tdi = ext[nbits-1-i];
        end
        @(posedge clk); #1;
        tshift = 1'b0; tdi = 1'b0; tupdate = 1'b1;
        @(posedge clk); #1;
        tupdate = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((seq_busy || !fifo_empty || rsp_active || bist_if.busy_in) && n < budget);
        if (n >= budget) check("quiet_timeout", n, 0);
    endtask

    task automatic check_status(input string tag);
        $display("[TB] %s: cmd_count=%0d fail=%0b load_err=%0b timeout=%0b",
                 tag, cmd_count, fail_flag, load_err, timeout_err);
        check({tag, "_cmd_count"}, cmd_count, exp_cnt);
        check({tag, "_fail_flag"}, fail_flag, exp_fail);
        check({tag, "_load_err"}, load_err, exp_load_err);
        check({tag, "_timeout_err"}, timeout_err, exp_timeout);
        check({tag, "_fifo_empty"}, fifo_empty, (m_occ == 0));
        check({tag, "_seq_busy"}, seq_busy, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_gen++;
        rsp_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!bist_if.busy_in && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, bist_if.busy_in, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nbits;
        logic [SW-1:0] w;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_scan", bist_if.scan, 0);
        check("rst_ts", bist_if.ts, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_fail_flag", fail_flag, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_load_err", load_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk); #1 rst = 1'b1;

        // single command, with tupdate-to-ts latency
        rsp_delay = 2; rsp_len = 10; rsp_pf = 1'b0; rsp_never = 1'b0;
        load_word(24'h1234FA, 24);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bist_if.ts && k < 10);
        check("ts_latency", k, 3);
        wait_quiet(200);
        check_status("single");

        // bad word lengths
        load_word(24'hABCDEF, 23);
        @(negedge clk); #1;
        check_status("short");
        apply_reset();
        load_word(24'h5A5A5A, 25);
        @(negedge clk); #1;
        check_status("long");
        apply_reset();

        // failing command, then a command that never starts
        rsp_pf = 1'b1; rsp_delay = 1; rsp_len = 4;
        load_word(24'h00F00F, 24);
        wait_quiet(200);
        check_status("fail");
        rsp_pf = 1'b0; rsp_never = 1'b1;
        load_word(24'h777777, 24);
        wait_quiet(200);
        check_status("timeout");
        rsp_never = 1'b0;
        apply_reset();

        // FIFO fill and overflow while the first command is held busy
        rsp_hold = 1'b1; rsp_len = 3; rsp_delay = 1;
        load_word(24'h100001, 24);
        wait_busy("ovf_busy_seen");
        for (int i = 2; i <= 6; i++) begin
            load_word(SW'(24'h100000 + i), 24);
            @(negedge clk); #1;
            $display("[TB] overflow load %0d: occ=%0d full=%0b load_err=%0b", i, m_occ, fifo_full, load_err);
            check("ovf_fifo_full", fifo_full, (m_occ == DEPTH));
            check("ovf_load_err", load_err, exp_load_err);
        end
        rsp_hold = 1'b0;
        wait_quiet(1000);
        check_status("overflow");

        // reset while the BIST block is busy
        rsp_hold = 1'b1;
        load_word(24'hC0FFEE, 24);
        wait_busy("mid_busy_seen");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_ts", bist_if.ts, 0);
        check("mid_rst_scan", bist_if.scan, 0);
        check("mid_rst_fifo_empty", fifo_empty, 1);
        check("mid_rst_seq_busy", seq_busy, 0);
        rsp_gen++;
        rsp_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        check_status("mid_rst");

        // randomized commands and word lengths
        for (int i = 0; i < 12; i++) begin
            w = SW'($urandom);
            nbits = ($urandom_range(0, 9) < 7) ? SW : int'($urandom_range(20, 28));
            rsp_pf    = 1'($urandom_range(0, 1));
            rsp_delay = $urandom_range(0, 8);
            rsp_len   = $urandom_range(1, 12);
            rsp_never = ($urandom_range(0, 5) == 0);
            $display("[TB] rand %0d: word=%06h bits=%0d pf=%0b delay=%0d len=%0d never=%0b",
                     i, w, nbits, rsp_pf, rsp_delay, rsp_len, rsp_never);
            load_word(w, nbits);
            wait_quiet(300);
            check_status("rand");
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
